// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences requests through the shared 8-bit ALU; define ALU_SEQ_WIDE_EN for two-pass ADD16/SUB16
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic [15:0] reqA,
  input  logic [15:0] reqB,
  input  logic [2:0]  reqShamt,
  output logic [7:0]  aluOperand1,
  output logic [7:0]  aluOperand2,
  output logic [2:0]  aluFunc,
  output logic        aluCarryIn,
  output logic        shiftImmediateEnable,
  output logic [2:0]  shiftImmediate,
  input  logic [7:0]  aluResult,
  input  logic        aluCarryOut,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [15:0] rspResult,
  output logic        rspCarry,
  output logic        rspError
);
`ifdef ALU_SEQ_WIDE_EN
  typedef enum logic [1:0] {IDLE, PASS_LO, PASS_HI, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PASS_LO, DONE} state_t;
`endif
  state_t state, state_nxt;
  logic [2:0] op_q, shamt_q, func;
  logic [15:0] a_q, b_q, result;
  logic carry, is_wide, is_shift, is_arith, drive, hi;
  assign is_wide = op_q[2] & op_q[1];
  assign is_shift = op_q[2] & ~op_q[1];
  assign is_arith = op_q[2] ~^ op_q[1];
  assign func = is_wide ? {2'b00, op_q[0]} : op_q;
`ifdef ALU_SEQ_WIDE_EN
  assign drive = state == PASS_LO || state == PASS_HI;
  assign hi = state == PASS_HI;
  assign rspError = 1'b0;
`else
  logic error, unused_hi;
  assign drive = state == PASS_LO && !is_wide;
  assign hi = 1'b0;
  assign rspError = error;
  assign unused_hi = ^{a_q[15:8], b_q[15:8]};
`endif
  assign rspResult = result;
  assign rspCarry = carry;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state and ALU-facing outputs; the high pass chains the captured carry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = reqValid ? PASS_LO : IDLE;
`ifdef ALU_SEQ_WIDE_EN
      PASS_LO: state_nxt = is_wide ? PASS_HI : DONE;
      PASS_HI: state_nxt = DONE;
`else
      PASS_LO: state_nxt = DONE;
`endif
      DONE: state_nxt = rspReady ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
    reqReady = state == IDLE;
    rspValid = state == DONE;
    aluOperand1 = drive ? (hi ? a_q[15:8] : a_q[7:0]) : 8'h00;
    aluOperand2 = drive && !is_shift ? (hi ? b_q[15:8] : b_q[7:0]) : 8'h00;
    aluFunc = drive ? func : 3'd0;
    aluCarryIn = drive && (hi ? carry : op_q[0] && is_arith);
    shiftImmediateEnable = drive && is_shift;
    shiftImmediate = drive && is_shift ? shamt_q : 3'd0;
  end
  // request latch and per-pass capture of the ALU result; carry is kept only for add/sub
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= 3'd0;
      a_q <= 16'h0000;
      b_q <= 16'h0000;
      shamt_q <= 3'd0;
      result <= 16'h0000;
      carry <= 1'b0;
`ifndef ALU_SEQ_WIDE_EN
      error <= 1'b0;
`endif
    end else begin
      if (state == IDLE && reqValid) begin
        op_q <= reqOp;
        a_q <= reqA;
        b_q <= reqB;
        shamt_q <= reqShamt;
      end
      if (state == PASS_LO) begin
        result <= {8'h00, drive ? aluResult : 8'h00};
        carry <= drive && is_arith && aluCarryOut;
`ifndef ALU_SEQ_WIDE_EN
        error <= is_wide;
`endif
      end
      if (hi) begin
        result[15:8] <= aluResult;
        carry <= aluCarryOut;
      end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl with a behavioural ALU and reference model
module tb_alu_seq_ctrl;
`ifdef ALU_SEQ_WIDE_EN
  localparam logic WIDE = 1'b1;
`else
  localparam logic WIDE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, reqValid = 1'b0, rspReady = 1'b1;
  logic [2:0] reqOp = 3'd0, reqShamt = 3'd0;
  logic [15:0] reqA = 16'h0000, reqB = 16'h0000;
  logic reqReady, aluCarryIn, shiftImmediateEnable, aluCarryOut, rspValid, rspCarry, rspError;
  logic [7:0] aluOperand1, aluOperand2, aluResult;
  logic [2:0] aluFunc, shiftImmediate;
  logic [15:0] rspResult;
  int checks = 0, errors = 0, lat;
  logic [7:0] lo_op1, lo_op2, hi_op1, hi_op2;
  logic [2:0] lo_func, hi_func, lo_sh;
  logic lo_cin, hi_cin, lo_sie;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqA(reqA), .reqB(reqB), .reqShamt(reqShamt), .aluOperand1(aluOperand1),
    .aluOperand2(aluOperand2), .aluFunc(aluFunc), .aluCarryIn(aluCarryIn),
    .shiftImmediateEnable(shiftImmediateEnable), .shiftImmediate(shiftImmediate),
    .aluResult(aluResult), .aluCarryOut(aluCarryOut), .rspValid(rspValid),
    .rspReady(rspReady), .rspResult(rspResult), .rspCarry(rspCarry), .rspError(rspError)
  );

  always #5 clk = ~clk;

  // ALU plus input mux; logic ops and shifts report carry-out 1 so the block must mask it
  logic [7:0] b_eff;
  logic [8:0] s;
  always_comb begin
    b_eff = shiftImmediateEnable ? {5'd0, shiftImmediate} : aluOperand2;
    s = 9'd0;
    case (aluFunc)
      3'd0: s = {1'b0, aluOperand1} + {1'b0, b_eff} + {8'd0, aluCarryIn};
      3'd1: s = {1'b0, aluOperand1} + {1'b0, ~b_eff} + {8'd0, aluCarryIn};
      3'd2: s = {1'b1, aluOperand1 & b_eff};
      3'd3: s = {1'b1, aluOperand1 ^ b_eff};
      3'd4: s = {1'b1, aluOperand1 << b_eff[2:0]};
      3'd5: s = {1'b1, aluOperand1 >> b_eff[2:0]};
      default: s = 9'd0;
    endcase
  end
  assign aluResult = s[7:0];
  assign aluCarryOut = s[8];

  typedef struct {
    logic [2:0] op;
    logic [15:0] a, b;
    logic [2:0] sh;
    logic [15:0] res;
    logic cy, er;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // result as arithmetic on whole operands: {error, carry, result}
  function automatic logic [17:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [2:0] sh);
    int x, y, r;
    logic c;
    x = int'(a[7:0]);
    y = int'(b[7:0]);
    c = 1'b0;
    case (op)
      3'd0: begin r = x + y; c = r > 255; end
      3'd1: begin r = x - y; c = x >= y; end
      3'd2: r = x & y;
      3'd3: r = x ^ y;
      3'd4: r = x << sh;
      3'd5: r = x >> sh;
      3'd6: begin r = int'(a) + int'(b); c = r > 65535; end
      default: begin r = int'(a) - int'(b); c = a >= b; end
    endcase
    if (op < 3'd6) r = r & 255;
    r = r & 65535;
    return (op >= 3'd6 && !WIDE) ? 18'h20000 : {1'b0, c, r[15:0]};
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] sh);
    int busy_bad;
    busy_bad = 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqOp = op; reqA = a; reqB = b; reqShamt = sh; rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    {lo_op1, lo_op2, lo_func, lo_cin, lo_sie, lo_sh} = '0;
    {hi_op1, hi_op2, hi_func, hi_cin} = '0;
    while (!rspValid && lat < 8) begin
      if (reqReady) busy_bad++;
      if (lat == 1) begin
        lo_op1 = aluOperand1; lo_op2 = aluOperand2; lo_func = aluFunc;
        lo_cin = aluCarryIn; lo_sie = shiftImmediateEnable; lo_sh = shiftImmediate;
      end
      if (lat == 2) begin
        hi_op1 = aluOperand1; hi_op2 = aluOperand2; hi_func = aluFunc; hi_cin = aluCarryIn;
      end
      @(negedge clk);
      lat++;
    end
    chk("busy_req_ready", 32'(busy_bad), 32'd0);
    chk("done_req_ready", 32'(reqReady), 32'd0);
    chk("done_alu_zero", 32'({aluOperand1, aluOperand2, aluFunc, aluCarryIn,
                              shiftImmediateEnable, shiftImmediate}), 32'd0);
  endtask

  task automatic run_vec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] sh, input logic [17:0] exp);
    do_op(op, a, b, sh);
    chk($sformatf("op%0d_latency", op), 32'(lat), (op[2] & op[1] & WIDE) ? 32'd3 : 32'd2);
    chk($sformatf("op%0d_result a=%h b=%h", op, a, b), 32'(rspResult), 32'(exp[15:0]));
    chk($sformatf("op%0d_carry a=%h b=%h", op, a, b), 32'(rspCarry), 32'(exp[16]));
    chk($sformatf("op%0d_error", op), 32'(rspError), 32'(exp[17]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int rst_rsp;
    logic [2:0] rop, rsh;
    logic [15:0] ra, rb;
    tbl[0]  = '{3'd0, 16'h00F0, 16'h0020, 3'd0, 16'h0010, 1'b1, 1'b0};
    tbl[1]  = '{3'd0, 16'hAB01, 16'hCD02, 3'd0, 16'h0003, 1'b0, 1'b0};
    tbl[2]  = '{3'd1, 16'h0010, 16'h0020, 3'd0, 16'h00F0, 1'b0, 1'b0};
    tbl[3]  = '{3'd1, 16'h0005, 16'h0005, 3'd0, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{3'd2, 16'h00F0, 16'h003C, 3'd0, 16'h0030, 1'b0, 1'b0};
    tbl[5]  = '{3'd3, 16'h005A, 16'h00FF, 3'd0, 16'h00A5, 1'b0, 1'b0};
    tbl[6]  = '{3'd4, 16'h0081, 16'h00FF, 3'd3, 16'h0008, 1'b0, 1'b0};
    tbl[7]  = '{3'd5, 16'h0081, 16'h0000, 3'd3, 16'h0010, 1'b0, 1'b0};
    tbl[8]  = '{3'd6, 16'h12FF, 16'h0001, 3'd0, WIDE ? 16'h1300 : 16'h0000, 1'b0, !WIDE};
    tbl[9]  = '{3'd7, 16'h0100, 16'h0001, 3'd0, WIDE ? 16'h00FF : 16'h0000, WIDE, !WIDE};
    tbl[10] = '{3'd6, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, WIDE, !WIDE};
    tbl[11] = '{3'd7, 16'h0001, 16'h0002, 3'd0, WIDE ? 16'hFFFF : 16'h0000, 1'b0, !WIDE};
    #2;
    chk("rst_req_ready", 32'(reqReady), 32'd1);
    chk("rst_rsp", 32'({rspValid, rspResult, rspCarry, rspError}), 32'd0);
    chk("rst_alu_zero", 32'({aluOperand1, aluOperand2, aluFunc, aluCarryIn,
                             shiftImmediateEnable, shiftImmediate}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++)
      run_vec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, {tbl[i].er, tbl[i].cy, tbl[i].res});
    run_vec(3'd0, 16'h00F0, 16'h0020, 3'd0, ref_op(3'd0, 16'h00F0, 16'h0020, 3'd0));
    chk("add_lo_func_cin", 32'({lo_func, lo_cin}), 32'd0);
    chk("add_lo_operands", 32'({lo_op1, lo_op2}), 32'hF020);
    run_vec(3'd1, 16'h0033, 16'h0011, 3'd0, ref_op(3'd1, 16'h0033, 16'h0011, 3'd0));
    chk("sub_lo_func_cin", 32'({lo_func, lo_cin}), 32'h3);
    run_vec(3'd4, 16'h0081, 16'h00FF, 3'd3, ref_op(3'd4, 16'h0081, 16'h00FF, 3'd3));
    chk("slli_lo", 32'({lo_sie, lo_sh, lo_op2, lo_func, lo_op1}), 32'({1'b1, 3'd3, 8'h00, 3'd4, 8'h81}));
    run_vec(3'd6, 16'h12FF, 16'h0001, 3'd0, ref_op(3'd6, 16'h12FF, 16'h0001, 3'd0));
`ifdef ALU_SEQ_WIDE_EN
    chk("add16_lo", 32'({lo_op1, lo_op2, lo_func, lo_cin}), 32'({8'hFF, 8'h01, 3'd0, 1'b0}));
    chk("add16_hi", 32'({hi_op1, hi_op2, hi_func, hi_cin}), 32'({8'h12, 8'h00, 3'd0, 1'b1}));
    run_vec(3'd7, 16'h0100, 16'h0001, 3'd0, ref_op(3'd7, 16'h0100, 16'h0001, 3'd0));
    chk("sub16_lo", 32'({lo_func, lo_cin}), 32'h3);
    chk("sub16_hi", 32'({hi_op1, hi_op2, hi_func, hi_cin}), 32'({8'h01, 8'h00, 3'd1, 1'b0}));
`else
    chk("wide_off_alu_zero", 32'({lo_op1, lo_op2, lo_func, lo_cin, lo_sie, lo_sh}), 32'd0);
`endif
    // backpressure: response held while rspReady is low, a new request is ignored
    @(negedge clk);
    reqValid = 1'b1; reqOp = 3'd3; reqA = 16'h005A; reqB = 16'h00FF; rspReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    reqValid = 1'b1; reqOp = 3'd0; reqA = 16'h0001; reqB = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 32'({rspValid, reqReady, rspResult}), 32'({1'b1, 1'b0, 16'h00A5}));
      @(negedge clk);
    end
    rspReady = 1'b1;
    reqValid = 1'b0;
    @(negedge clk);
    chk("bp_release", 32'({reqReady, rspValid}), 32'h2);
    // reset in the middle of an operation aborts it
    @(negedge clk);
    reqValid = 1'b1; reqOp = WIDE ? 3'd6 : 3'd0; reqA = 16'h12FF; reqB = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
`ifdef ALU_SEQ_WIDE_EN
    @(negedge clk);
    chk("rst_mid_hi_cin", 32'(aluCarryIn), 32'd1);
`endif
    chk("rst_mid_busy", 32'(reqReady), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(reqReady), 32'd1);
    chk("rst_mid_rsp", 32'({rspValid, rspResult, rspCarry, rspError}), 32'd0);
    chk("rst_mid_alu", 32'({aluOperand1, aluOperand2, aluFunc, aluCarryIn,
                            shiftImmediateEnable, shiftImmediate}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rst_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rspValid) rst_rsp++;
    end
    chk("rst_no_rsp", 32'(rst_rsp), 32'd0);
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rsh = 3'($urandom);
      run_vec(rop, ra, rb, rsh, ref_op(rop, ra, rb, rsh));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer that owns the shared 8-bit ALU and its input mux. It accepts one ALU operation request at a time over a valid/ready handshake and drives the ALU operands, function, carry-in and shift-immediate select. It sequences 16-bit add/sub as two 8-bit passes through the same ALU and returns the result over a valid/ready response channel. It sits between the execute-stage decoder and the ALU/ALU-input-mux pair.

## Interface
- No parameters; the datapath is fixed at 8-bit ALU and 16-bit request/response.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock domain only.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request.
- reqOp  in  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLLI, 5 SRLI, 6 ADD16, 7 SUB16.
- reqA  in  16  operand A; only [7:0] is used by 8-bit ops.
- reqB  in  16  operand B; only [7:0] is used by 8-bit ops; ignored by shifts.
- reqShamt  in  3  shift immediate.
- aluOperand1  out  8  ALU input 1.
- aluOperand2  out  8  ALU input 2.
- aluFunc  out  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL.
- aluCarryIn  out  1  ALU carry-in.
- shiftImmediateEnable  out  1  selects shiftImmediate as ALU input 2.
- shiftImmediate  out  3  shift amount to the mux.
- aluResult  in  8  combinational ALU result.
- aluCarryOut  in  1  combinational ALU carry-out.
- rspValid  out  1  response held valid.
- rspReady  in  1  consumer accepts the response.
- rspResult  out  16  result.
- rspCarry  out  1  final carry-out; 0 for logic ops and shifts.
- rspError  out  1  unsupported op.

## Operation
- States: IDLE, PASS_LO, PASS_HI, DONE.
- IDLE:
  - reqReady=1.
  - On reqValid, latch reqOp/reqA/reqB/reqShamt and go to PASS_LO.
- PASS_LO:
  - Drive the latched low bytes to the ALU.
  - aluCarryIn=1 for SUB/SUB16, 0 otherwise.
  - ADD16 maps to aluFunc 0; SUB16 maps to aluFunc 1.
  - Capture aluResult into result[7:0] and aluCarryOut into the carry register.
  - 8-bit ops go to DONE with result[15:8]=0.
  - ADD16/SUB16 go to PASS_HI.
- PASS_HI:
  - Drive the latched high bytes with the same aluFunc; aluCarryIn = captured carry.
  - Capture result[15:8] and the carry; go to DONE.
- Shifts (SLLI/SRLI):
  - shiftImmediateEnable=1, shiftImmediate=latched reqShamt, aluOperand2=0.
  - rspCarry=0.
- DONE:
  - rspValid=1 with rspResult/rspCarry/rspError stable.
  - On rspReady, return to IDLE.
- Outside PASS_LO/PASS_HI, all ALU-facing outputs are 0.
- reqReady=0 in every state except IDLE; a request presented then is not accepted.

## Timing
- Reset, asynchronous:
  - state=IDLE, all latched operands and results 0.
  - reqReady=1; rspValid=0, rspResult=0, rspCarry=0, rspError=0.
  - All ALU-facing outputs 0.
- Reset asserted mid-operation aborts it; no response is produced.
- Latency, with request accepted at edge N: 8-bit ops give rspValid from cycle N+2; 16-bit ops from N+3.
- Response:
  - Held indefinitely while rspReady=0.
  - rspValid & rspReady at edge M: IDLE at M+1, next request accepted at the earliest M+1.
- Throughput: one op per 3 cycles (8-bit) or 4 cycles (16-bit) with rspReady tied high.
- ALU path is combinational within one cycle; the block registers the ALU output at the end of each PASS cycle.

## Configuration
- ALU_SEQ_WIDE_EN defined:
  - ADD16/SUB16 execute as two passes.
  - rspError is constant 0.
- ALU_SEQ_WIDE_EN undefined:
  - PASS_HI is absent.
  - Ops 6/7 are accepted, skip the ALU (no ALU-facing output is nonzero) and reach DONE at N+2 with rspResult=0, rspCarry=0, rspError=1.
  - Ops 0-5 are unchanged.

## Test plan
- ADD: A=0x00F0, B=0x0020, rspReady=1 -> rspValid at N+2, rspResult=0x0010, rspCarry=1, rspError=0; reqReady=0 for cycles N+1..N+2.
- ADD16 (macro on): A=0x12FF, B=0x0001 -> PASS_LO aluCarryIn=0; PASS_HI aluCarryIn=1, operands 0x12/0x00; rspResult=0x1300, rspCarry=0 at N+3.
- SUB16 (macro on): A=0x0100, B=0x0001 -> aluCarryIn=1 in PASS_LO, rspResult=0x00FF, rspCarry=1.
- SLLI: A=0x0081, shamt=3 -> in PASS_LO shiftImmediateEnable=1, shiftImmediate=3, aluOperand2=0x00; rspResult=0x0008, rspCarry=0.
- Backpressure: XOR 0x5A^0xFF with rspReady low 5 cycles -> rspValid and rspResult=0x00A5 held, reqReady=0 throughout; rspReady high -> reqReady=1 next cycle.
- Reset during PASS_HI -> immediate IDLE, reqReady=1, no rspValid.
- Macro off, op 6 -> rspValid at N+2 with rspResult=0, rspError=1.
